note_lane_renderer: RTL and testbench

//  Sequences the VGA adapter pixel port to render the 10-slot note lane once per frame tick.
//  For each slot it paints one square, scanning pixels row-major:
//   - red note -> RED; yellow note -> YELLOW; no note -> BLACK (erase).

---
 rtl/note_lane_renderer_if.sv | 14 +
 rtl/note_lane_renderer.sv | 108 ++++++++++
 tb/tb_note_lane_renderer.sv | 87 ++++++++
 3 files changed

// File: rtl/note_lane_renderer_if.sv
// note_lane_renderer_if: groups the game-controller handshake, the note sequences and the vga_adapter pixel port.
interface note_lane_renderer_if #(parameter int NUM_SQ = 10);
    logic              start;
    logic [NUM_SQ-1:0] red_sequence;
    logic [NUM_SQ-1:0] yellow_sequence;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;
    logic              plot;
    logic              busy;
    logic              done;
    modport master (output start, red_sequence, yellow_sequence, input x, y, colour, plot, busy, done);
    modport slave (input start, red_sequence, yellow_sequence, output x, y, colour, plot, busy, done);
endinterface

// File: rtl/note_lane_renderer.sv
// note_lane_renderer: paints the note lane one pixel per cycle into the vga_adapter.
// Define HIT_ZONE_EN to prefix each pass with a blue hit-target square.
module note_lane_renderer #(
    parameter int NUM_SQ  = 10,
    parameter int SQ_LOG2 = 2,
    parameter int X_START = 10,
    parameter int X_STEP  = 10,
    parameter int Y_ROW   = 112
) (
    input logic clk,
    input logic resetn,
    note_lane_renderer_if.slave bus
);
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] BLUE   = 3'b001;
    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
    state_t                 state, state_d;
    logic [3:0]             slot, slot_d;
    logic [2*SQ_LOG2-1:0]   pix, pix_d;
    logic [NUM_SQ-1:0]      red_q, red_d, yel_q, yel_d;
    logic [7:0]             x_d;
    logic [6:0]             y_d;
    logic [2:0]             colour_d;
    logic                   plot_d, busy_d, done_d, marker;
`ifdef HIT_ZONE_EN
    localparam logic [7:0] X_FIRST = 8'(X_START - X_STEP);
    localparam logic [3:0] LAST    = 4'(NUM_SQ);
    assign marker = slot == 4'd0;
`else
    localparam logic [7:0] X_FIRST = 8'(X_START);
    localparam logic [3:0] LAST    = 4'(NUM_SQ - 1);
    assign marker = 1'b0;
`endif
    // Snapshots shift right once per note slot so bit 0 is always the slot being drawn.
    always_comb begin
        state_d  = state;
        slot_d   = slot;
        pix_d    = pix;
        red_d    = red_q;
        yel_d    = yel_q;
        x_d      = bus.x;
        y_d      = bus.y;
        colour_d = bus.colour;
        plot_d   = 1'b0;
        busy_d   = bus.busy;
        done_d   = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_d = LOAD;
                busy_d  = 1'b1;
            end
            LOAD: begin
                red_d   = bus.red_sequence;
                yel_d   = bus.yellow_sequence;
                slot_d  = 4'd0;
                pix_d   = '0;
                state_d = DRAW;
            end
            DRAW: begin
                plot_d   = 1'b1;
                x_d      = X_FIRST + 8'(slot) * 8'(X_STEP) + 8'(pix[SQ_LOG2-1:0]);
                y_d      = 7'(Y_ROW) + 7'(pix[2*SQ_LOG2-1:SQ_LOG2]);
                colour_d = marker ? BLUE : red_q[0] ? RED : yel_q[0] ? YELLOW : BLACK;
                pix_d    = pix + 1'b1;
                if (&pix) begin
                    slot_d  = slot + 4'd1;
                    red_d   = marker ? red_q : red_q >> 1;
                    yel_d   = marker ? yel_q : yel_q >> 1;
                    state_d = slot == LAST ? DONE : DRAW;
                end
            end
            default: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            slot       <= 4'd0;
            pix        <= '0;
            red_q      <= '0;
            yel_q      <= '0;
            bus.x      <= 8'd0;
            bus.y      <= 7'd0;
            bus.colour <= BLACK;
            bus.plot   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            state      <= state_d;
            slot       <= slot_d;
            pix        <= pix_d;
            red_q      <= red_d;
            yel_q      <= yel_d;
            bus.x      <= x_d;
            bus.y      <= y_d;
            bus.colour <= colour_d;
            bus.plot   <= plot_d;
            bus.busy   <= busy_d;
            bus.done   <= done_d;
        end
    end
endmodule

// File: tb/tb_note_lane_renderer.sv
// tb_note_lane_renderer: directed passes checked pixel-by-pixel against a hand-written lane model.
module tb_note_lane_renderer;
`ifdef HIT_ZONE_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif
    localparam int NPIX = (10 + OFS) * 16;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    note_lane_renderer_if #(.NUM_SQ(10)) bus();
    note_lane_renderer dut (.clk(clk), .resetn(resetn), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [17:0] pixel(input int k, input logic [9:0] r, input logic [9:0] yv);
        int s = k / 16;
        int p = k % 16;
        int q = s - OFS;
        logic [2:0] c;
        if (q < 0) c = 3'b001;
        else c = r[q] ? 3'b100 : yv[q] ? 3'b110 : 3'b000;
        return {8'(10 - 10 * OFS + s * 10 + p % 4), 7'(112 + p / 4), c};
    endfunction
    // Edge e counts rising edges after the one that samples start (edge 0); sampled on the following negedge.
    task automatic run_pass(input logic [9:0] r, input logic [9:0] yv, input int repulse_at, input int toggle_at);
        int plots = 0;
        int dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.red_sequence = r;
        bus.yellow_sequence = yv;
        for (int e = 0; e <= NPIX + 4; e++) begin
            @(negedge clk);
            bus.start = (e + 1 == repulse_at);
            if (e + 1 == toggle_at) bus.red_sequence = 10'h3FF;
            check("plot", bus.plot, e >= 2 && e <= NPIX + 1);
            check("busy", bus.busy, e <= NPIX + 1);
            check("done", bus.done, e == NPIX + 2);
            if (bus.plot && e >= 2) check("pixel", {bus.x, bus.y, bus.colour}, pixel(e - 2, r, yv));
            plots += int'(bus.plot);
            dones += int'(bus.done);
        end
        check("plot_count", plots, NPIX);
        check("done_count", dones, 1);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.red_sequence = '0;
        bus.yellow_sequence = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
        resetn = 1'b1;
        run_pass(10'b0000000001, 10'b0000000010, 0, 0);
        run_pass(10'h3FF, 10'h3FF, 0, 0);
        run_pass(10'h000, 10'h000, 0, 5);
        run_pass(10'h2AA, 10'h155, 50, 0);
        run_pass(10'h0F0, 10'h30F, 0, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_draw_plot", bus.plot, 1);
        resetn = 1'b0;
        #1;
        check("async_reset", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
        @(posedge clk);
        #1;
        check("reset_hold", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_idle", {bus.plot, bus.busy, bus.done}, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
